// File: rtl/game_countdown_timer_if.sv
// ---------------------------------------------------------------------------
// game_countdown_timer_if
//   Groups the countdown timer's control pulses and display/status outputs.
//   master : the game controller side (drives tick/start/pause, reads status)
//   slave  : the countdown timer itself
// Signals
//   tick_1hz  one-cycle 1 Hz pulse from the seconds divider
//   start     one-cycle pulse: load preset and run
//   pause     one-cycle pulse: toggle RUN <-> PAUSED
//   min_tens, min_ones, sec_tens, sec_ones   BCD remaining time
//   running   high while counting
//   time_up   high once 00:00 is reached
//   expire    one-cycle pulse when 00:00 is reached
//   warn      remaining time at or below the warning threshold
// ---------------------------------------------------------------------------
interface game_countdown_timer_if;
    logic       tick_1hz;
    logic       start;
    logic       pause;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       time_up;
    logic       expire;
    logic       warn;

    modport master (
        output tick_1hz, start, pause,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  running, time_up, expire, warn
    );

    modport slave (
        input  tick_1hz, start, pause,
        output min_tens, min_ones, sec_tens, sec_ones,
        output running, time_up, expire, warn
    );
endinterface

// File: rtl/game_countdown_timer.sv
// ---------------------------------------------------------------------------
// game_countdown_timer
//   Match-length countdown. Loads a preset MM:SS (held as BCD digits for the
//   7-segment scanner) and counts down one second per tick_1hz pulse until
//   00:00, then flags time-up. Supports start/restart and pause/resume.
// Parameters
//   START_MM  preset minutes (0..99)
//   START_SS  preset seconds (0..59); 00:00 preset is illegal
//   WARN_SS   warning threshold in seconds (only used with TIMER_WARN_EN)
// Ports
//   clock     system clock
//   reset_n   asynchronous active-low reset
//   bus       game_countdown_timer_if.slave (control pulses, digits, status)
// Configuration macro
//   TIMER_WARN_EN  when defined, builds a 13-bit binary shadow down-counter
//                  and a registered warn flag; otherwise warn is tied to 0.
// ---------------------------------------------------------------------------
module game_countdown_timer #(
    parameter int START_MM = 2,
    parameter int START_SS = 0,
    parameter int WARN_SS  = 10
) (
    input  logic                   clock,
    input  logic                   reset_n,
    game_countdown_timer_if.slave  bus
);

    // Elaboration-time legality check of the preset.
    generate
        if ((START_MM > 99) || (START_MM < 0) || (START_SS > 59) || (START_SS < 0) ||
            ((START_MM == 0) && (START_SS == 0)) || (WARN_SS < 0)) begin : g_bad_param
            $error("game_countdown_timer: illegal START_MM/START_SS/WARN_SS");
        end
    endgenerate

    localparam logic [3:0] PRE_MT = 4'(START_MM / 10);
    localparam logic [3:0] PRE_MO = 4'(START_MM % 10);
    localparam logic [3:0] PRE_ST = 4'(START_SS / 10);
    localparam logic [3:0] PRE_SO = 4'(START_SS % 10);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e     state_q;
    logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic       running_q, time_up_q, expire_q;

    logic [3:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    logic       is_last_s;
    logic       dec_fire_s;

    // Start has top priority; a tick only counts in RUN with no start/pause.
    assign dec_fire_s = (state_q == ST_RUN) && !bus.start && !bus.pause && bus.tick_1hz;
    assign is_last_s  = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                        (sec_tens_q == 4'd0) && (sec_ones_q == 4'd1);

    // BCD borrow chain: next digits after one decrement of the displayed time.
    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        if (sec_ones_q != 4'd0) begin
            sec_ones_d = sec_ones_q - 4'd1;
        end else begin
            sec_ones_d = 4'd9;
            if (sec_tens_q != 4'd0) begin
                sec_tens_d = sec_tens_q - 4'd1;
            end else begin
                sec_tens_d = 4'd5;
                if (min_ones_q != 4'd0) begin
                    min_ones_d = min_ones_q - 4'd1;
                end else begin
                    min_ones_d = 4'd9;
                    min_tens_d = min_tens_q - 4'd1;
                end
            end
        end
    end

    // Main FSM: state, BCD digits and registered status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            min_tens_q <= PRE_MT;
            min_ones_q <= PRE_MO;
            sec_tens_q <= PRE_ST;
            sec_ones_q <= PRE_SO;
            running_q  <= 1'b0;
            time_up_q  <= 1'b0;
            expire_q   <= 1'b0;
        end else begin
            expire_q <= 1'b0;
            if (bus.start) begin
                // Start reloads the preset and runs from every state.
                state_q    <= ST_RUN;
                min_tens_q <= PRE_MT;
                min_ones_q <= PRE_MO;
                sec_tens_q <= PRE_ST;
                sec_ones_q <= PRE_SO;
                running_q  <= 1'b1;
                time_up_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_RUN: begin
                        if (bus.pause) begin
                            state_q   <= ST_PAUSED;
                            running_q <= 1'b0;
                        end else if (dec_fire_s) begin
                            min_tens_q <= min_tens_d;
                            min_ones_q <= min_ones_d;
                            sec_tens_q <= sec_tens_d;
                            sec_ones_q <= sec_ones_d;
                            if (is_last_s) begin
                                state_q   <= ST_DONE;
                                running_q <= 1'b0;
                                time_up_q <= 1'b1;
                                expire_q  <= 1'b1;
                            end else begin
                                state_q <= ST_RUN;
                            end
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_PAUSED: begin
                        if (bus.pause) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end else begin
                            state_q <= ST_PAUSED;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                        time_up_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.min_tens = min_tens_q;
    assign bus.min_ones = min_ones_q;
    assign bus.sec_tens = sec_tens_q;
    assign bus.sec_ones = sec_ones_q;
    assign bus.running  = running_q;
    assign bus.time_up  = time_up_q;
    assign bus.expire   = expire_q;

`ifdef TIMER_WARN_EN
    localparam logic [12:0] PRE_SECS = 13'(START_MM * 60 + START_SS);
    localparam logic [12:0] WARN_LIM = 13'(WARN_SS);

    logic [12:0] rem_q;
    logic        warn_q;

    // Binary shadow of the remaining seconds drives the warning compare,
    // avoiding a BCD magnitude comparison.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_q  <= PRE_SECS;
            warn_q <= 1'b0;
        end else if (bus.start) begin
            rem_q  <= PRE_SECS;
            warn_q <= 1'b0;
        end else if (dec_fire_s) begin
            rem_q  <= rem_q - 13'd1;
            // Reaching 00:00 enters DONE, where warn is cleared.
            warn_q <= (rem_q != 13'd1) && ((rem_q - 13'd1) <= WARN_LIM);
        end else begin
            rem_q  <= rem_q;
            warn_q <= warn_q;
        end
    end

    assign bus.warn = warn_q;
`else
    assign bus.warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_game_countdown_timer
//   Two timers (presets 02:00 and 00:02) share one randomized stimulus stream.
//   A reference model tracks remaining time as plain seconds and derives the
//   expected digits/status every cycle; directed checks use fixed constants.
// ---------------------------------------------------------------------------
module tb_game_countdown_timer;

    localparam int WARN_SS = 10;

    logic clock;
    logic reset_n;
    logic tick_r, start_r, pause_r;

    int n_tests;
    int n_fail;

    game_countdown_timer_if bus_a ();
    game_countdown_timer_if bus_b ();

    assign bus_a.tick_1hz = tick_r;
    assign bus_a.start    = start_r;
    assign bus_a.pause    = pause_r;
    assign bus_b.tick_1hz = tick_r;
    assign bus_b.start    = start_r;
    assign bus_b.pause    = pause_r;

    game_countdown_timer #(.START_MM(2), .START_SS(0), .WARN_SS(WARN_SS)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    game_countdown_timer #(.START_MM(0), .START_SS(2), .WARN_SS(WARN_SS)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed word: {mt,mo,st,so,running,time_up,expire,warn}
    logic [19:0] obs_a, obs_b;
    assign obs_a = {bus_a.min_tens, bus_a.min_ones, bus_a.sec_tens, bus_a.sec_ones,
                    bus_a.running, bus_a.time_up, bus_a.expire, bus_a.warn};
    assign obs_b = {bus_b.min_tens, bus_b.min_ones, bus_b.sec_tens, bus_b.sec_ones,
                    bus_b.running, bus_b.time_up, bus_b.expire, bus_b.warn};

    // Reference model: 0 idle, 1 run, 2 paused, 3 done
    int m_state [2];
    int m_rem   [2];
    int m_pre   [2];
    bit m_exp   [2];
    bit m_warn  [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;
            m_rem[i]   = m_pre[i];
            m_exp[i]   = 1'b0;
            m_warn[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit s, input bit p, input bit t);
        m_exp[i] = 1'b0;
        if (s) begin
            m_rem[i]   = m_pre[i];
            m_state[i] = 1;
            m_warn[i]  = 1'b0;
        end else if (p) begin
            if (m_state[i] == 1)      m_state[i] = 2;
            else if (m_state[i] == 2) m_state[i] = 1;
        end else if (t && m_state[i] == 1) begin
            m_rem[i] = m_rem[i] - 1;
            if (m_rem[i] == 0) begin
                m_state[i] = 3;
                m_exp[i]   = 1'b1;
                m_warn[i]  = 1'b0;
            end else begin
                m_warn[i] = (m_rem[i] <= WARN_SS);
            end
        end
    endtask

    function automatic logic [19:0] model_word(input int i);
        int mm, ss;
        bit w;
        mm = m_rem[i] / 60;
        ss = m_rem[i] % 60;
`ifdef TIMER_WARN_EN
        w = m_warn[i];
`else
        w = 1'b0;
`endif
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                (m_state[i] == 1), (m_state[i] == 3), m_exp[i], w};
    endfunction

    // One clock: drive inputs, advance model on the edge, compare 1 ns later.
    task automatic cyc(input bit s, input bit p, input bit t);
        start_r = s;
        pause_r = p;
        tick_r  = t;
        @(posedge clock);
        model_step(0, s, p, t);
        model_step(1, s, p, t);
        #1;
        check_val("a_model", 32'(obs_a), 32'(model_word(0)));
        check_val("b_model", 32'(obs_b), 32'(model_word(1)));
        start_r = 1'b0;
        pause_r = 1'b0;
        tick_r  = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        m_pre[0] = 120;
        m_pre[1] = 2;
        reset_n  = 1'b0;
        tick_r   = 1'b0;
        start_r  = 1'b0;
        pause_r  = 1'b0;
        model_reset();
        #12;
        check_val("rst_a_digits", 32'(obs_a[19:4]), 32'h0200);
        check_val("rst_a_status", 32'(obs_a[3:0]), 32'h0);
        check_val("rst_b_digits", 32'(obs_b[19:4]), 32'h0002);
        reset_n = 1'b1;

        // Ticks and pause in IDLE change nothing
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        check_val("idle_digits", 32'(obs_a[19:4]), 32'h0200);
        check_val("idle_running", 32'(obs_a[3]), 32'h0);

        // Start, then borrow chain
        cyc(1'b1, 1'b0, 1'b0);
        check_val("start_running", 32'(obs_a[3]), 32'h1);
        cyc(1'b0, 1'b0, 1'b1);
        check_val("a_0159", 32'(obs_a[19:4]), 32'h0159);
        check_val("b_0001", 32'(obs_b[19:4]), 32'h0001);
        cyc(1'b0, 1'b0, 1'b1);
        check_val("b_zero", 32'(obs_b[19:4]), 32'h0000);
        check_val("b_expire", 32'(obs_b[3:1]), 32'b011);
        cyc(1'b0, 1'b0, 1'b1);
        check_val("b_hold_zero", 32'(obs_b[19:4]), 32'h0000);
        check_val("b_expire_once", 32'(obs_b[3:1]), 32'b010);
        for (int i = 0; i < 58; i++) cyc(1'b0, 1'b0, 1'b1);
        check_val("a_0059", 32'(obs_a[19:4]), 32'h0059);

        // Pause / resume at 01:30
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0, 1'b1);
        check_val("a_0130", 32'(obs_a[19:4]), 32'h0130);
        cyc(1'b0, 1'b1, 1'b0);
        check_val("pause_running", 32'(obs_a[3]), 32'h0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1);
        check_val("paused_hold", 32'(obs_a[19:4]), 32'h0130);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check_val("resume_0129", 32'(obs_a[19:4]), 32'h0129);

        // Priority: start beats tick, pause beats tick
        for (int i = 0; i < 44; i++) cyc(1'b0, 1'b0, 1'b1);
        check_val("a_0045", 32'(obs_a[19:4]), 32'h0045);
        cyc(1'b1, 1'b0, 1'b1);
        check_val("start_tick", 32'(obs_a[19:3]), 32'h00401);
        cyc(1'b0, 1'b1, 1'b1);
        check_val("pause_tick", 32'(obs_a[19:3]), 32'h00400);
        cyc(1'b0, 1'b1, 1'b0);

`ifdef TIMER_WARN_EN
        // Warning window
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 109; i++) cyc(1'b0, 1'b0, 1'b1);
        check_val("warn_11s", 32'(obs_a[0]), 32'h0);
        cyc(1'b0, 1'b0, 1'b1);
        check_val("warn_10s", 32'(obs_a[0]), 32'h1);
        cyc(1'b0, 1'b1, 1'b0);
        check_val("warn_paused", 32'(obs_a[0]), 32'h1);
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b1);
        check_val("warn_1s", 32'(obs_a[0]), 32'h1);
        cyc(1'b0, 1'b0, 1'b1);
        check_val("warn_done", 32'(obs_a[0]), 32'h0);
`endif

        // Reset in the middle of a count
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 115; i++) cyc(1'b0, 1'b0, 1'b1);
        check_val("pre_rst_0005", 32'(obs_a[19:4]), 32'h0005);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_val("midrst_digits", 32'(obs_a[19:4]), 32'h0200);
        check_val("midrst_status", 32'(obs_a[3:0]), 32'h0);
        check_val("midrst_model_b", 32'(obs_b), 32'(model_word(1)));
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 1) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
